// File: rtl/compare_serial_if.sv
// Operand/result handshake bundle for the serial magnitude comparator.
// Producer drives the operand side and out_ready; the comparator drives the rest.
interface compare_serial_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         gt;
  logic         eq;
  logic         lt;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, gt, eq, lt
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, gt, eq, lt
  );
endinterface

// File: rtl/compare_serial.sv
// Serial MSB-first magnitude comparator: latency 1..W edges after accept, stops at first differing bit.
// Result is held in DONE until out_ready; no new operands are taken until the block is back in IDLE.
module compare_serial #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  compare_serial_if.slave  bus
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_y;
  logic          r_gt;
  logic          r_eq;
  logic          r_lt;
  logic          w_bit_diff;
  logic          w_in_ready;
  logic          w_out_valid;

  assign w_bit_diff = r_a[r_idx] ^ r_b[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_SCAN;
      S_SCAN:  if (w_bit_diff || (r_idx == '0)) w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs come from state alone, so there is no input-to-output path.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready  = 1'b1;
      S_DONE:  w_out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_y   <= '0;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_idx <= IW'(W - 1);
          end
        end
        S_SCAN: begin
          // The operand holding the 1 at the first differing bit is the larger one.
          if (w_bit_diff) begin
            r_gt <= r_a[r_idx];
            r_lt <= r_b[r_idx];
            r_eq <= 1'b0;
            r_y  <= r_a[r_idx] ? r_a : r_b;
          end else if (r_idx == '0) begin
            r_gt <= 1'b0;
            r_lt <= 1'b0;
            r_eq <= 1'b1;
            r_y  <= W'(1);
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.y         = r_y;
  assign bus.gt        = r_gt;
  assign bus.eq        = r_eq;
  assign bus.lt        = r_lt;
endmodule

// File: tb/tb_compare_serial.sv
// Directed and exhaustive bench for compare_serial at W=4.
module tb_compare_serial;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  compare_serial_if #(.W(4)) bus ();

  compare_serial #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a pair while in IDLE, returns edges from accept to out_valid (capped at 20).
  task automatic issue(input logic [3:0] ia, input logic [3:0] ib, output int lat);
    bus.in_valid = 1'b1;
    bus.a        = ia;
    bus.b        = ib;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.y, bus.gt, bus.eq, bus.lt} !== 9'b0_1_0000_000) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b ir=%b y=%0d gt=%b eq=%b lt=%b, want ov=0 ir=1 y=0 flags=000",
               bus.out_valid, bus.in_ready, bus.y, bus.gt, bus.eq, bus.lt);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_release: got ov=%b ir=%b, want ov=0 ir=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_gt();
    int lat;
    issue(4'd9, 4'd3, lat);
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL gt_latency: got %0d, want 1", lat);
    end
    n_checks++;
    if ({bus.y, bus.gt, bus.eq, bus.lt} !== {4'd9, 3'b100}) begin
      n_fail++;
      $display("FAIL gt_result: got y=%0d gt=%b eq=%b lt=%b, want y=9 gt=1 eq=0 lt=0", bus.y, bus.gt, bus.eq, bus.lt);
    end
    drain();
  endtask

  task automatic test_lt();
    int lat;
    issue(4'd5, 4'd6, lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL lt_latency: got %0d, want 3", lat);
    end
    n_checks++;
    if ({bus.y, bus.gt, bus.eq, bus.lt} !== {4'd6, 3'b001}) begin
      n_fail++;
      $display("FAIL lt_result: got y=%0d gt=%b eq=%b lt=%b, want y=6 gt=0 eq=0 lt=1", bus.y, bus.gt, bus.eq, bus.lt);
    end
    drain();
  endtask

  task automatic test_eq_ambiguous();
    int lat;
    issue(4'd1, 4'd1, lat);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL eq_latency: got %0d, want 4", lat);
    end
    n_checks++;
    if ({bus.y, bus.gt, bus.eq, bus.lt} !== {4'd1, 3'b010}) begin
      n_fail++;
      $display("FAIL eq_result: got y=%0d gt=%b eq=%b lt=%b, want y=1 gt=0 eq=1 lt=0", bus.y, bus.gt, bus.eq, bus.lt);
    end
    drain();
    issue(4'd1, 4'd0, lat);
    n_checks++;
    if (lat !== 4 || {bus.y, bus.gt, bus.eq, bus.lt} !== {4'd1, 3'b100}) begin
      n_fail++;
      $display("FAIL ambig_result: got lat=%0d y=%0d gt=%b eq=%b lt=%b, want lat=4 y=1 gt=1 eq=0 lt=0",
               lat, bus.y, bus.gt, bus.eq, bus.lt);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(4'd12, 4'd10, lat);
    n_checks++;
    if (lat !== 2 || {bus.y, bus.gt, bus.eq, bus.lt} !== {4'd12, 3'b100}) begin
      n_fail++;
      $display("FAIL bp_first: got lat=%0d y=%0d flags=%b%b%b, want lat=2 y=12 flags=100",
               lat, bus.y, bus.gt, bus.eq, bus.lt);
    end
    bus.in_valid = 1'b1;
    bus.a        = 4'd3;
    bus.b        = 4'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({bus.out_valid, bus.in_ready, bus.y, bus.gt, bus.eq, bus.lt} !== {2'b10, 4'd12, 3'b100}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b y=%0d flags=%b%b%b, want ov=1 ir=0 y=12 flags=100",
                 i, bus.out_valid, bus.in_ready, bus.y, bus.gt, bus.eq, bus.lt);
      end
    end
    drain();
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release: got ov=%b ir=%b, want ov=0 ir=1", bus.out_valid, bus.in_ready);
    end
    issue(4'd3, 4'd7, lat);
    n_checks++;
    if (lat !== 2 || {bus.y, bus.gt, bus.eq, bus.lt} !== {4'd7, 3'b001}) begin
      n_fail++;
      $display("FAIL bp_next: got lat=%0d y=%0d flags=%b%b%b, want lat=2 y=7 flags=001",
               lat, bus.y, bus.gt, bus.eq, bus.lt);
    end
    drain();
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    bus.in_valid = 1'b1;
    bus.a        = 4'd2;
    bus.b        = 4'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.y, bus.gt, bus.eq, bus.lt} !== 9'b0_1_0000_000) begin
      n_fail++;
      $display("FAIL mid_reset: got ov=%b ir=%b y=%0d flags=%b%b%b, want ov=0 ir=1 y=0 flags=000",
               bus.out_valid, bus.in_ready, bus.y, bus.gt, bus.eq, bus.lt);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_hold: got ov=%b, want 0", bus.out_valid);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(4'd2, 4'd3, lat);
    n_checks++;
    if (lat !== 4 || {bus.y, bus.gt, bus.eq, bus.lt} !== {4'd3, 3'b001}) begin
      n_fail++;
      $display("FAIL after_reset: got lat=%0d y=%0d flags=%b%b%b, want lat=4 y=3 flags=001",
               lat, bus.y, bus.gt, bus.eq, bus.lt);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int acc;
    int ovs;
    acc = 0;
    ovs = 0;
    bus.a         = 4'd8;
    bus.b         = 4'd0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int e = 0; e < 9; e++) begin
      if (bus.in_ready) acc++;
      @(posedge clk); #1;
      if (bus.out_valid) ovs++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++;
    if (acc !== 3 || ovs !== 3) begin
      n_fail++;
      $display("FAIL back_to_back: got accepts=%0d results=%0d over 9 edges, want 3 and 3", acc, ovs);
    end
  endtask

  task automatic test_exhaustive();
    int          lat;
    int          exp_lat;
    logic [3:0]  ey;
    logic [2:0]  ef;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        exp_lat = 4;
        ey      = 4'd1;
        ef      = 3'b010;
        for (int p = 0; p < 4; p++) begin
          if (ia[p] != ib[p]) begin
            exp_lat = 4 - p;
            ey      = (ia[p]) ? ia[3:0] : ib[3:0];
            ef      = (ia[p]) ? 3'b100 : 3'b001;
          end
        end
        issue(ia[3:0], ib[3:0], lat);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        n_checks++;
        if (lat !== exp_lat) begin
          n_fail++;
          $display("FAIL exh_latency a=%0d b=%0d: got %0d, want %0d", ia, ib, lat, exp_lat);
        end
        n_checks++;
        if ({bus.out_valid, bus.y, bus.gt, bus.eq, bus.lt} !== {1'b1, ey, ef}) begin
          n_fail++;
          $display("FAIL exh_result a=%0d b=%0d: got ov=%b y=%0d flags=%b%b%b, want ov=1 y=%0d flags=%b",
                   ia, ib, bus.out_valid, bus.y, bus.gt, bus.eq, bus.lt, ey, ef);
        end
        drain();
      end
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    test_reset();
    test_gt();
    test_lt();
    test_eq_ambiguous();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
